// File: rtl/motor_nn_if.sv
// Request/response bundle between the motor sequencer and the half-rate network wrapper.
// Master side launches the sample and start/valid strobes; slave side returns done and result.
interface motor_nn_if #(
  parameter int DATA_W = 18
) ();
  logic              nn_ap_start;
  logic              nn_in_vld;
  logic [DATA_W-1:0] nn_r;
  logic [DATA_W-1:0] nn_pos;
  logic [DATA_W-1:0] nn_vel;
  logic              nn_done;
  logic [DATA_W-1:0] nn_out;

  modport master (
    output nn_ap_start, nn_in_vld, nn_r, nn_pos, nn_vel,
    input  nn_done, nn_out
  );

  modport slave (
    input  nn_ap_start, nn_in_vld, nn_r, nn_pos, nn_vel,
    output nn_done, nn_out
  );
endinterface

// File: rtl/motor_nn_sequencer.sv
// Fixed-rate MPC sequencer: ticks every PERIOD_CYCLES, launches one network transaction per
// accepted tick, captures the result or flags a timeout, and counts ticks dropped while busy.
module motor_nn_sequencer #(
  parameter int DATA_W             = 18,
  parameter int PERIOD_CYCLES      = 200,
  parameter int START_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES     = 150
) (
  input  logic              clk_1,
  input  logic              ap_rst,
  input  logic              ce_1,
  input  logic              enable,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] pos_in,
  input  logic [DATA_W-1:0] vel_in,
  motor_nn_if.master        nn,
  output logic [DATA_W-1:0] u_out,
  output logic              u_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        overrun_cnt,
  output logic [15:0]       last_latency
);
  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_period;
  logic [3:0]        r_pulse;
  logic [TO_W-1:0]   r_wait;
  logic [15:0]       r_lat;
  logic              r_start;
  logic [DATA_W-1:0] r_nn_r;
  logic [DATA_W-1:0] r_nn_pos;
  logic [DATA_W-1:0] r_nn_vel;
  logic [DATA_W-1:0] r_u_out;
  logic              r_u_valid;
  logic              r_busy;
  logic              r_timeout_err;
  logic [7:0]        r_overrun;
  logic [15:0]       r_last_lat;
  logic              w_tick;

  assign w_tick = enable && (r_period == CNT_W'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst) begin
      r_period <= '0;
    end else if (ce_1) begin
      if (!enable || w_tick) r_period <= '0;
      else                   r_period <= r_period + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_1 or posedge ap_rst) begin
    if (ap_rst) begin
      r_state       <= S_IDLE;
      r_pulse       <= '0;
      r_wait        <= '0;
      r_lat         <= '0;
      r_start       <= 1'b0;
      r_nn_r        <= '0;
      r_nn_pos      <= '0;
      r_nn_vel      <= '0;
      r_u_out       <= '0;
      r_u_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= '0;
      r_last_lat    <= '0;
    end else if (ce_1) begin
      r_u_valid <= 1'b0;
      // A dropped tick outranks a simultaneous clear and leaves the count at one.
      if (w_tick && r_state != S_IDLE) begin
        if (err_clr)                r_overrun <= 8'd1;
        else if (r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
      end else if (err_clr) begin
        r_overrun <= '0;
      end
      if (err_clr) r_timeout_err <= 1'b0;
      if (r_lat != 16'hFFFF) r_lat <= r_lat + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_nn_r   <= r_in;
            r_nn_pos <= pos_in;
            r_nn_vel <= vel_in;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_pulse  <= 4'd1;
            r_lat    <= 16'd1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (r_pulse == 4'(START_PULSE_CYCLES)) begin
            r_start <= 1'b0;
            r_wait  <= TO_W'(1);
            r_state <= S_WAIT;
          end else begin
            r_pulse <= r_pulse + 4'd1;
          end
        end
        S_WAIT: begin
          // Done in the final allowed cycle still counts as a good transaction.
          if (nn.nn_done) begin
            r_u_out    <= nn.nn_out;
            r_u_valid  <= 1'b1;
            r_last_lat <= r_lat;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_wait == TO_W'(TIMEOUT_CYCLES)) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wait <= r_wait + TO_W'(1);
          end
        end
        default: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign nn.nn_ap_start = r_start;
  assign nn.nn_in_vld   = r_start;
  assign nn.nn_r        = r_nn_r;
  assign nn.nn_pos      = r_nn_pos;
  assign nn.nn_vel      = r_nn_vel;
  assign u_out          = r_u_out;
  assign u_valid        = r_u_valid;
  assign busy           = r_busy;
  assign timeout_err    = r_timeout_err;
  assign overrun_cnt    = r_overrun;
  assign last_latency   = r_last_lat;
endmodule

// File: tb/tb_motor_nn_sequencer.sv
// Directed bench: dut_a (TIMEOUT=12) covers launch/capture/timeout/freeze/reset,
// dut_b (TIMEOUT=25) covers ticks dropped while waiting and overrun saturation.
module tb_motor_nn_sequencer;
  localparam int DW = 18;

  logic          clk_1 = 1'b0;
  logic          ap_rst, ce_1, enable, enable_b, err_clr;
  logic [DW-1:0] r_in, pos_in, vel_in;
  logic [DW-1:0] u_out_a, u_out_b;
  logic          u_valid_a, u_valid_b, busy_a, busy_b, to_a, to_b;
  logic [7:0]    ovr_a, ovr_b;
  logic [15:0]   lat_a, lat_b;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_fail = 0;

  motor_nn_if #(.DATA_W(DW)) nn_a ();
  motor_nn_if #(.DATA_W(DW)) nn_b ();

  motor_nn_sequencer #(.DATA_W(DW), .PERIOD_CYCLES(20), .START_PULSE_CYCLES(2),
                       .TIMEOUT_CYCLES(12)) dut_a (
    .clk_1(clk_1), .ap_rst(ap_rst), .ce_1(ce_1), .enable(enable), .err_clr(err_clr),
    .r_in(r_in), .pos_in(pos_in), .vel_in(vel_in), .nn(nn_a),
    .u_out(u_out_a), .u_valid(u_valid_a), .busy(busy_a), .timeout_err(to_a),
    .overrun_cnt(ovr_a), .last_latency(lat_a)
  );

  motor_nn_sequencer #(.DATA_W(DW), .PERIOD_CYCLES(20), .START_PULSE_CYCLES(2),
                       .TIMEOUT_CYCLES(25)) dut_b (
    .clk_1(clk_1), .ap_rst(ap_rst), .ce_1(ce_1), .enable(enable_b), .err_clr(err_clr),
    .r_in(r_in), .pos_in(pos_in), .vel_in(vel_in), .nn(nn_b),
    .u_out(u_out_b), .u_valid(u_valid_b), .busy(busy_b), .timeout_err(to_b),
    .overrun_cnt(ovr_b), .last_latency(lat_b)
  );

  always #5 clk_1 = ~clk_1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ap_rst = 1'b1; ce_1 = 1'b1; enable = 1'b0; enable_b = 1'b0; err_clr = 1'b0;
    r_in = 18'h00100; pos_in = 18'h00200; vel_in = 18'h3FFFF;
    nn_a.nn_done = 1'b0; nn_a.nn_out = '0;
    nn_b.nn_done = 1'b0; nn_b.nn_out = '0;
    cyc(3);
    chk("rst_start", {31'd0, nn_a.nn_ap_start}, 32'd0);
    chk("rst_vld", {31'd0, nn_a.nn_in_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_u_out", {14'd0, u_out_a}, 32'd0);
    chk("rst_nn_r", {14'd0, nn_a.nn_r}, 32'd0);
    chk("rst_ovr", {24'd0, ovr_a}, 32'd0);
    chk("rst_lat", {16'd0, lat_a}, 32'd0);
    chk("rst_to", {31'd0, to_a}, 32'd0);

    // Test 1: first tick at cycle 19, capture at cycle 28.
    ap_rst = 1'b0; enable = 1'b1;
    cyc(19); chk("t1_start_c19", {31'd0, nn_a.nn_ap_start}, 32'd0);
    cyc(1);
    chk("t1_start_c20", {31'd0, nn_a.nn_ap_start}, 32'd1);
    chk("t1_vld_c20", {31'd0, nn_a.nn_in_vld}, 32'd1);
    chk("t1_nn_r", {14'd0, nn_a.nn_r}, 32'h00100);
    chk("t1_nn_pos", {14'd0, nn_a.nn_pos}, 32'h00200);
    chk("t1_nn_vel", {14'd0, nn_a.nn_vel}, 32'h3FFFF);
    chk("t1_busy_c20", {31'd0, busy_a}, 32'd1);
    r_in = 18'h00123;
    cyc(1); chk("t1_start_c21", {31'd0, nn_a.nn_ap_start}, 32'd1);
    cyc(1);
    chk("t1_start_c22", {31'd0, nn_a.nn_ap_start}, 32'd0);
    chk("t1_vld_c22", {31'd0, nn_a.nn_in_vld}, 32'd0);
    chk("t1_nn_r_hold", {14'd0, nn_a.nn_r}, 32'h00100);
    cyc(5); nn_a.nn_done = 1'b1; nn_a.nn_out = 18'h3FF00;
    chk("t1_uv_c27", {31'd0, u_valid_a}, 32'd0);
    cyc(1); nn_a.nn_done = 1'b0; nn_a.nn_out = '0;
    chk("t1_u_out", {14'd0, u_out_a}, 32'h3FF00);
    chk("t1_uv_c28", {31'd0, u_valid_a}, 32'd1);
    chk("t1_lat", {16'd0, lat_a}, 32'd8);
    chk("t1_busy_c28", {31'd0, busy_a}, 32'd0);
    cyc(1); chk("t1_uv_c29", {31'd0, u_valid_a}, 32'd0);

    // Test 2: timeout, relaunch on the next tick, err_clr.
    cyc(11);
    chk("t2_start_c40", {31'd0, nn_a.nn_ap_start}, 32'd1);
    chk("t2_nn_r", {14'd0, nn_a.nn_r}, 32'h00123);
    cyc(13);
    chk("t2_busy_c53", {31'd0, busy_a}, 32'd1);
    chk("t2_to_c53", {31'd0, to_a}, 32'd0);
    cyc(1);
    chk("t2_to_c54", {31'd0, to_a}, 32'd1);
    chk("t2_busy_c54", {31'd0, busy_a}, 32'd0);
    chk("t2_u_out", {14'd0, u_out_a}, 32'h3FF00);
    chk("t2_uv", {31'd0, u_valid_a}, 32'd0);
    cyc(6);
    chk("t2_relaunch", {31'd0, nn_a.nn_ap_start}, 32'd1);
    // Test 4 interleaved: done during LAUNCH is ignored.
    err_clr = 1'b1; nn_a.nn_done = 1'b1; nn_a.nn_out = 18'h00AAA;
    cyc(1); err_clr = 1'b0; nn_a.nn_done = 1'b0;
    chk("t2_to_clr", {31'd0, to_a}, 32'd0);
    chk("t4_uv_launch", {31'd0, u_valid_a}, 32'd0);
    cyc(1); chk("t4_uv_launch2", {31'd0, u_valid_a}, 32'd0);
    cyc(2); nn_a.nn_done = 1'b1; nn_a.nn_out = 18'h00555;
    cyc(1); nn_a.nn_out = 18'h00777;
    chk("t4_uv_c65", {31'd0, u_valid_a}, 32'd1);
    chk("t4_u_out", {14'd0, u_out_a}, 32'h00555);
    chk("t4_lat", {16'd0, lat_a}, 32'd5);
    cyc(1); nn_a.nn_done = 1'b0;
    chk("t4_uv_c66", {31'd0, u_valid_a}, 32'd0);
    chk("t4_u_out_hold", {14'd0, u_out_a}, 32'h00555);
    chk("t4_busy_c66", {31'd0, busy_a}, 32'd0);
    cyc(4); nn_a.nn_done = 1'b1; nn_a.nn_out = 18'h00999;
    cyc(1); nn_a.nn_done = 1'b0;
    chk("t4_uv_idle", {31'd0, u_valid_a}, 32'd0);
    chk("t4_u_out_idle", {14'd0, u_out_a}, 32'h00555);

    // Test 5: clock-enable freeze during LAUNCH stretches the pulse and hides from latency.
    cyc(9); chk("t5_start_c80", {31'd0, nn_a.nn_ap_start}, 32'd1);
    ce_1 = 1'b0;
    cyc(2); chk("t5_start_c82", {31'd0, nn_a.nn_ap_start}, 32'd1);
    cyc(3); chk("t5_start_c85", {31'd0, nn_a.nn_ap_start}, 32'd1);
    ce_1 = 1'b1;
    cyc(1); chk("t5_start_c86", {31'd0, nn_a.nn_ap_start}, 32'd1);
    cyc(1); chk("t5_start_c87", {31'd0, nn_a.nn_ap_start}, 32'd0);
    cyc(3); nn_a.nn_done = 1'b1; nn_a.nn_out = 18'h01234;
    cyc(1); nn_a.nn_done = 1'b0;
    chk("t5_uv", {31'd0, u_valid_a}, 32'd1);
    chk("t5_lat", {16'd0, lat_a}, 32'd6);
    chk("t5_u_out", {14'd0, u_out_a}, 32'h01234);

    // Test 6: asynchronous reset during WAIT.
    cyc(19); chk("t6_busy_pre", {31'd0, busy_a}, 32'd1);
    ap_rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_start", {31'd0, nn_a.nn_ap_start}, 32'd0);
    chk("t6_u_out", {14'd0, u_out_a}, 32'd0);
    chk("t6_nn_r", {14'd0, nn_a.nn_r}, 32'd0);
    chk("t6_lat", {16'd0, lat_a}, 32'd0);
    cyc(1); ap_rst = 1'b0;
    cyc(19); chk("t6_start_c19", {31'd0, nn_a.nn_ap_start}, 32'd0);
    cyc(1);
    chk("t6_start_c20", {31'd0, nn_a.nn_ap_start}, 32'd1);
    chk("t6_nn_r_c20", {14'd0, nn_a.nn_r}, 32'h00123);

    // Test 3 on dut_b: tick during WAIT dropped, then overrun saturation.
    cyc(1); enable_b = 1'b1;
    cyc(20); chk("t3_start_b20", {31'd0, nn_b.nn_ap_start}, 32'd1);
    cyc(20);
    chk("t3_ovr_b40", {24'd0, ovr_b}, 32'd1);
    chk("t3_busy_b40", {31'd0, busy_b}, 32'd1);
    cyc(1); nn_b.nn_done = 1'b1; nn_b.nn_out = 18'h2AAAA;
    cyc(1); nn_b.nn_done = 1'b0;
    chk("t3_uv_b42", {31'd0, u_valid_b}, 32'd1);
    chk("t3_lat_b42", {16'd0, lat_b}, 32'd22);
    chk("t3_u_out_b42", {14'd0, u_out_b}, 32'h2AAAA);
    chk("t3_busy_b42", {31'd0, busy_b}, 32'd0);
    cyc(3);
    chk("t3_start_b45", {31'd0, nn_b.nn_ap_start}, 32'd0);
    chk("t3_busy_b45", {31'd0, busy_b}, 32'd0);
    cyc(15); chk("t3_start_b60", {31'd0, nn_b.nn_ap_start}, 32'd1);
    cyc(10419);
    chk("t3_ovr_sat", {24'd0, ovr_b}, 32'd255);
    chk("t3_to_b", {31'd0, to_b}, 32'd1);
    err_clr = 1'b1;
    cyc(1); err_clr = 1'b0;
    chk("t3_ovr_clr_event", {24'd0, ovr_b}, 32'd1);
    chk("t3_to_clr_b", {31'd0, to_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
